// File: rtl/cpu_clock_conditioner_pkg.sv
// Shared FSM encoding and counter widths for the CPU clock conditioner.
package cpu_clock_pkg;

  localparam int DebounceWidth = 16;
  localparam int DivWidth      = 23;
  localparam int PulseWidth    = 8;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_STEP_HI  = 3'd1;
  localparam logic [2:0] ST_STEP_LO  = 3'd2;
  localparam logic [2:0] ST_WAIT_REL = 3'd3;
  localparam logic [2:0] ST_RST_HI   = 3'd4;
  localparam logic [2:0] ST_RST_LO   = 3'd5;
  localparam logic [2:0] ST_RST_WAIT = 3'd6;
  localparam logic [2:0] ST_RUN      = 3'd7;

  function automatic logic state_is_high(input logic [2:0] s);
    return (s == ST_STEP_HI) || (s == ST_RST_HI);
  endfunction

  function automatic logic state_in_reset(input logic [2:0] s);
    return (s == ST_RST_HI) || (s == ST_RST_LO) || (s == ST_RST_WAIT);
  endfunction

endpackage

// File: rtl/cpu_clock_conditioner_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, and
// single-cycle rise/fall pulses on the accepted level.
module btn_debounce
  import cpu_clock_pkg::*;
#(
  parameter int DebounceCycles = 32000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [DebounceWidth-1:0] CountMax = DebounceWidth'(DebounceCycles - 1);

  logic [1:0]               sync;
  logic [DebounceWidth-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      count <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      fall <= 1'b0;
      // Any cycle agreeing with the accepted level restarts the stability window.
      if (sync[1] == level) begin
        count <= '0;
      end else if (count == CountMax) begin
        count <= '0;
        level <= sync[1];
        rise  <= sync[1];
        fall  <= ~sync[1];
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_clock_conditioner.sv
// Step/reset button front end for the A09 CPU: one CPU clock period per step press,
// sequenced CPU reset, and a heartbeat divider. Optional free-run mode: CLK_FREERUN_EN.
module cpu_clock_conditioner
  import cpu_clock_pkg::*;
#(
  parameter int DebounceCycles = 32000,
  parameter int PulseCycles    = 8,
  parameter int ResetEdges     = 4,
  parameter int HeartbeatDiv   = 8000000,
  parameter int FreeRunDiv     = 8000000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic StepBtn,
  input  logic ResetBtn,
  input  logic RunSel,
  output logic CpuClk,
  output logic CpuReset_N,
  output logic ClkCyc,
  output logic Busy
);

  localparam logic [PulseWidth-1:0] PhaseMax   = PulseWidth'(PulseCycles - 1);
  localparam logic [PulseWidth-1:0] EdgeTarget = PulseWidth'(ResetEdges);
  localparam logic [DivWidth-1:0]   HbMax      = DivWidth'(HeartbeatDiv - 1);
  localparam logic [DivWidth-1:0]   RunMax     = DivWidth'(FreeRunDiv - 1);

  logic step_level, step_rise, step_fall;
  logic rst_level, rst_rise, rst_fall;

  btn_debounce #(.DebounceCycles(DebounceCycles)) u_step_db (
    .clk(Clk), .rst_n(Reset), .raw(StepBtn),
    .level(step_level), .rise(step_rise), .fall(step_fall)
  );

  btn_debounce #(.DebounceCycles(DebounceCycles)) u_rst_db (
    .clk(Clk), .rst_n(Reset), .raw(ResetBtn),
    .level(rst_level), .rise(rst_rise), .fall(rst_fall)
  );

  logic [2:0]            state, state_next;
  logic [PulseWidth-1:0] phase, edges;
  logic                  abort, phase_run, phase_done, clk_next;

`ifdef CLK_FREERUN_EN
  logic [1:0]          run_sync_ff;
  logic                run_sync, run_tick;
  logic [DivWidth-1:0] run_count;

  assign run_sync = run_sync_ff[1];
  assign run_tick = (run_count == RunMax);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      run_sync_ff <= '0;
      run_count   <= '0;
    end else begin
      run_sync_ff <= {run_sync_ff[0], RunSel};
      if (state != ST_RUN || run_tick) run_count <= '0;
      else                             run_count <= run_count + 1'b1;
    end
  end

  logic unused;
  assign unused = &{1'b0, step_fall, rst_fall};
`else
  logic unused;
  assign unused = &{1'b0, step_fall, rst_fall, RunSel, RunMax[0]};
`endif

  assign abort = rst_rise || (state == ST_IDLE && rst_level);
  // A high state whose clock has not risen yet (after reset or an abort) holds its phase one cycle.
  assign phase_run  = !(state_is_high(state) && !CpuClk);
  assign phase_done = phase_run && (phase == PhaseMax);
  assign Busy       = (state != ST_IDLE);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (step_rise) state_next = ST_STEP_HI;
`ifdef CLK_FREERUN_EN
        else if (run_sync) state_next = ST_RUN;
`endif
      end
      ST_STEP_HI:  if (phase_done) state_next = ST_STEP_LO;
      ST_STEP_LO:  if (phase_done) state_next = ST_WAIT_REL;
      ST_WAIT_REL: if (!step_level) state_next = ST_IDLE;
      ST_RST_HI:   if (phase_done) state_next = ST_RST_LO;
      ST_RST_LO:   if (phase_done) state_next = (edges < EdgeTarget) ? ST_RST_HI : ST_RST_WAIT;
      ST_RST_WAIT: if (!rst_level) state_next = ST_IDLE;
`ifdef CLK_FREERUN_EN
      ST_RUN:      if (!run_sync && (!CpuClk || run_tick)) state_next = ST_IDLE;
`endif
      default:     state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_RST_HI;

    clk_next = state_is_high(state_next);
`ifdef CLK_FREERUN_EN
    if (state_next == ST_RUN) clk_next = (state == ST_RUN) ? (CpuClk ^ run_tick) : 1'b1;
`endif
    if (abort) clk_next = 1'b0;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= ST_RST_HI;
      phase      <= '0;
      edges      <= '0;
      CpuClk     <= 1'b0;
      CpuReset_N <= 1'b0;
    end else begin
      state      <= state_next;
      CpuClk     <= clk_next;
      CpuReset_N <= !state_in_reset(state_next);
      if (abort || state_next != state)      phase <= '0;
      else if (phase_run && phase != PhaseMax) phase <= phase + 1'b1;
      if (abort || !(state == ST_RST_HI || state == ST_RST_LO)) edges <= '0;
      else if (state == ST_RST_HI && phase_done)                edges <= edges + 1'b1;
    end
  end

  logic [DivWidth-1:0] hb_count;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hb_count <= '0;
      ClkCyc   <= 1'b0;
    end else if (hb_count == HbMax) begin
      hb_count <= '0;
      ClkCyc   <= ~ClkCyc;
    end else begin
      hb_count <= hb_count + 1'b1;
    end
  end

endmodule
